// File: rtl/audio_out_sched.sv
// rtl/audio_out_sched.sv - MMIO stereo sample FIFO with playback scheduler FSM (optional IRQ: AUDIO_OUT_SCHED_IRQ_EN)
module audio_out_sched #(
    parameter logic [31:0] BASE  = 32'h40000040,
    parameter int          DEPTH = 8,
    parameter int          PRIME = 4
) (
    input  logic        CLK,
    input  logic        AUD_DACLRCK,
    input  logic        iMemWrite,
    input  logic        iMemRead,
    input  logic [31:0] iwMemAddress,
    input  logic [31:0] iwMemWriteData,
    output logic [31:0] oMemReadData,
    output logic        oReadHit,
    input  logic        iSampleReq,
    output logic [15:0] oSampleL,
    output logic [15:0] oSampleR,
    output logic        oSampleValid
`ifdef AUDIO_OUT_SCHED_IRQ_EN
    ,
    output logic        oIrq
`endif
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);
    localparam logic [4:0] PRIME_C = 5'(PRIME);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2,
        STARVE = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [4:0]    count;
    logic [4:0]    count_n;
    logic          enable;
    logic          enable_n;
    logic          unf;
    logic          ovf;
    logic          irq_bit;

    logic wr_data;
    logic wr_ctrl;
    logic flush;
    logic clrstk;
    logic empty;
    logic full;
    logic pop;
    logic push_ok;
    logic ovf_set;
    logic unf_set;

    // Bus decode and FIFO accept/drop decisions; flush overrides both push and pop
    always_comb begin
        wr_data  = iMemWrite && (iwMemAddress == BASE);
        wr_ctrl  = iMemWrite && (iwMemAddress == BASE + 32'd8);
        flush    = wr_ctrl && iwMemWriteData[1];
        clrstk   = wr_ctrl && iwMemWriteData[2];
        empty    = (count == 5'd0);
        full     = (count == DEPTH_C);
        pop      = !flush && iSampleReq && (state == RUN) && !empty;
        unf_set  = !flush && iSampleReq && (state == RUN) && empty;
        push_ok  = !flush && wr_data && (!full || pop);
        ovf_set  = !flush && wr_data && full && !pop;
        enable_n = wr_ctrl ? iwMemWriteData[0] : enable;
    end

    // Next occupancy: a simultaneous push and pop cancel out
    always_comb begin
        count_n = count;
        if (flush) begin
            count_n = 5'd0;
        end else if (push_ok && !pop) begin
            count_n = count + 5'd1;
        end else if (pop && !push_ok) begin
            count_n = count - 5'd1;
        end
    end

    // Sample storage; contents are discarded by pointer reset, so no reset here
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wptr] <= iwMemWriteData;
        end
    end

    // Pointers, sticky flags, scheduler FSM and registered sample outputs
    always_ff @(posedge CLK or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            rptr         <= '0;
            wptr         <= '0;
            count        <= 5'd0;
            enable       <= 1'b0;
            unf          <= 1'b0;
            ovf          <= 1'b0;
            state        <= IDLE;
            oSampleL     <= 16'd0;
            oSampleR     <= 16'd0;
            oSampleValid <= 1'b0;
        end else begin
            enable <= enable_n;
            count  <= count_n;
            if (flush) begin
                rptr <= '0;
                wptr <= '0;
            end else begin
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                if (push_ok) begin
                    wptr <= wptr + 1'b1;
                end
            end
            unf <= (unf && !clrstk) || unf_set;
            ovf <= (ovf && !clrstk) || ovf_set;

            // Every request is answered; only a real pop carries data
            oSampleValid <= iSampleReq;
            if (iSampleReq) begin
                oSampleL <= pop ? mem[rptr][31:16] : 16'd0;
                oSampleR <= pop ? mem[rptr][15:0]  : 16'd0;
            end

            if (!enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= FILL;
                    FILL:    state <= (count >= PRIME_C) ? RUN : FILL;
                    RUN: begin
                        if (flush) begin
                            state <= FILL;
                        end else if (unf_set) begin
                            state <= STARVE;
                        end
                    end
                    STARVE:  state <= (count >= PRIME_C) ? RUN : STARVE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef AUDIO_OUT_SCHED_IRQ_EN
    // Refill request: enabled but below the priming threshold
    always_ff @(posedge CLK or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            oIrq <= 1'b0;
        end else begin
            oIrq <= enable_n && (count_n < PRIME_C);
        end
    end

    // STATUS mirror of the interrupt line
    always_comb begin
        irq_bit = oIrq;
    end
`else
    // No interrupt line in this build; STATUS bit reads 0
    always_comb begin
        irq_bit = 1'b0;
    end
`endif

    // Combinational register read port
    always_comb begin
        oMemReadData = 32'd0;
        oReadHit     = 1'b0;
        if (iMemRead) begin
            if (iwMemAddress == BASE + 32'd4) begin
                oReadHit     = 1'b1;
                oMemReadData = {20'd0, irq_bit, state, ovf, unf, full, empty, count};
            end else if (iwMemAddress == BASE + 32'd8) begin
                oReadHit     = 1'b1;
                oMemReadData = {31'd0, enable};
            end
        end
    end

endmodule

// File: doc/audio_out_sched.md
AUDIO_OUT_SCHED -- requirements
Module: audio_out_sched

Interface
REQ-001 The block SHALL provide parameter BASE, default 32'h40000040, the byte address of the first of three word-aligned MMIO registers.
REQ-002 The block SHALL provide parameter DEPTH, default 8, the sample FIFO depth in stereo entries, a power of two from 2 to 16.
REQ-003 The block SHALL provide parameter PRIME, default 4, the FIFO occupancy required before playback starts or resumes, from 1 to DEPTH.
REQ-004 Port CLK, input, 1 bit: processor clock; all state SHALL change on its rising edge.
REQ-005 Port AUD_DACLRCK, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port iMemWrite, input, 1 bit: processor store strobe.
REQ-007 Port iMemRead, input, 1 bit: processor load strobe.
REQ-008 Port iwMemAddress, input, 32 bits: processor byte address.
REQ-009 Port iwMemWriteData, input, 32 bits: store data.
REQ-010 Port oMemReadData, output, 32 bits: load data, combinational.
REQ-011 Port oReadHit, output, 1 bit: high when iMemRead is high and the address is BASE+4 or BASE+8.
REQ-012 Port iSampleReq, input, 1 bit: codec-side one-CLK request for the next stereo sample.
REQ-013 Ports oSampleL and oSampleR, outputs, 16 bits each: held sample words.
REQ-014 Port oSampleValid, output, 1 bit: one-CLK pulse marking new sample words.

Function
REQ-015 The register map SHALL be: BASE+0 DATA (write-only); BASE+4 STATUS (read-only); BASE+8 CTRL (read/write); reads of any other address SHALL return 0 with oReadHit low.
REQ-016 A DATA write SHALL push {L=wdata[31:16], R=wdata[15:0]}; a push when the FIFO is full SHALL be dropped and set sticky OVF.
REQ-017 STATUS SHALL read as: [4:0] count; [5] empty; [6] full; [7] UNF sticky; [8] OVF sticky; [10:9] state; [31:11] 0.
REQ-018 A CTRL write SHALL act on three bits: bit0 ENABLE is stored; bit1 FLUSH, write-1 self-clearing, empties the FIFO; bit2 CLRSTK, write-1, clears UNF and OVF. A CTRL read SHALL return {31'b0, ENABLE}.
REQ-019 The FSM SHALL have four states, encoded IDLE=0, FILL=1, RUN=2, STARVE=3.
REQ-020 The FSM transitions SHALL be: IDLE->FILL when ENABLE=1; FILL->RUN when count>=PRIME; RUN->STARVE when a request finds the FIFO empty; STARVE->RUN when count>=PRIME; any state->IDLE when ENABLE=0.
REQ-021 In RUN, iSampleReq at edge n with count>0 SHALL pop the head entry, and oSampleL/R SHALL show it with oSampleValid high after edge n+1 (1-cycle latency).
REQ-022 iSampleReq in IDLE, FILL or STARVE SHALL pop nothing, SHALL drive oSampleL/R to 0, and SHALL pulse oSampleValid.
REQ-023 iSampleReq in RUN with an empty FIFO SHALL drive 0s, pulse oSampleValid, set UNF, and enter STARVE.
REQ-024 A simultaneous push and pop in the same cycle SHALL leave count unchanged, and the push SHALL be accepted even when the FIFO is full.
REQ-025 FLUSH SHALL take priority over a same-cycle push or pop and SHALL move RUN to FILL when ENABLE stays 1.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL never exceed DEPTH.

Reset
REQ-027 AUD_DACLRCK low SHALL immediately clear: pointers, count, ENABLE, UNF, OVF, state (to IDLE), oSampleL/R, oSampleValid and, when present, oIrq.
REQ-028 Reset asserted mid-operation SHALL discard all FIFO contents, and the first push after release SHALL land in entry 0.

Configuration
REQ-029 Macro AUDIO_OUT_SCHED_IRQ_EN, when defined, SHALL add output oIrq (1 bit), registered, high while ENABLE=1 and count<PRIME, and SHALL make STATUS[11] mirror oIrq.
REQ-030 Without AUDIO_OUT_SCHED_IRQ_EN, port oIrq SHALL NOT exist and STATUS[11] SHALL read 0.

Verification
REQ-031 Reset, write CTRL=1, push 0x11112222, 0x33334444, 0x55556666, 0x77778888 -> state reaches RUN after the 4th push; STATUS=0x404.
REQ-032 In RUN, pulse iSampleReq -> next cycle oSampleL=0x1111, oSampleR=0x2222, oSampleValid=1; count=3.
REQ-033 Perform 9 pushes with ENABLE=0 -> count=8, full=1, OVF=1; then CLRSTK -> OVF=0.
REQ-034 In RUN, issue 5 requests with 4 entries -> 5th returns 0/0, UNF=1, state=STARVE; 4 further pushes -> RUN.
REQ-035 With count=8, push and request in the same cycle -> count stays 8 and the pushed word is popped 8 requests later.
REQ-036 Drop AUD_DACLRCK while in RUN with count=3 -> STATUS=0x20, oSampleL/R=0 immediately; under AUDIO_OUT_SCHED_IRQ_EN, oIrq=1 after CTRL=1.
